// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared types and constants for the Am2904 shift sequencer.
//   state_e        - sequencer states (IDLE, SHIFT, DONE)
//   SH_*           - 5-bit {dir, link} shift codes that land on I[10:6]
//   COND_*         - 6-bit condition selects that land on I[5:0]
//   mk_shift_i()   - assembles the 13-bit Am2904 instruction for a shift cycle
package shift_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // {dir, link} shift codes
  localparam logic [4:0] SH_DN_ZERO   = 5'o06;
  localparam logic [4:0] SH_DN_ROT_RQ = 5'o17;
  localparam logic [4:0] SH_UP_ZERO   = 5'o26;
  localparam logic [4:0] SH_UP_ROT_RQ = 5'o37;

  // condition selects
  localparam logic [5:0] COND_MN  = 6'o56;
  localparam logic [5:0] COND_NMN = 6'o57;

  // I[12:11] = 00 forces the Am2904 carry-out to 0 during shifts
  localparam logic [1:0] I_CARRY_ZERO = 2'b00;

  function automatic logic [12:0] mk_shift_i(input logic [4:0] code,
                                             input logic [5:0] cond);
    return {I_CARRY_ZERO, code, cond};
  endfunction

endpackage

// File: rtl/shift_seq_cnt.sv
// shift_seq_cnt: paired step / remaining counter.
//   clk, nreset   - clock, async active-low reset
//   i_load        - clear steps and load remaining with i_load_val
//   i_load_val    - requested shift count
//   i_step        - one shift performed: steps++, remaining--
//   o_steps       - shifts performed since last load
//   o_tc          - terminal count: the current step is the last one
// Neither counter wraps: a step with remaining==0 is ignored.
module shift_seq_cnt
  import shift_seq_pkg::*;
#(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_step,
  output logic [CNT_W-1:0] o_steps,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_steps;
  logic [CNT_W-1:0] r_rem;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_steps <= '0;
      r_rem   <= '0;
    end else if (i_load) begin
      r_steps <= '0;
      r_rem   <= i_load_val;
    end else if (i_step && (r_rem != '0)) begin
      r_steps <= r_steps + 1'b1;
      r_rem   <= r_rem - 1'b1;
    end
  end

  assign o_steps = r_steps;
  assign o_tc    = (r_rem == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/shift_seq.sv
// shift_seq: multi-step shift sequencer driving an Am2904 status/shift unit.
// Optional feature macro: SHIFT_NORM_EN (early stop on CT for normalization).
//   clk, nreset     - clock, async active-low reset
//   start           - request strobe, accepted in IDLE only
//   dir, link       - shift direction / linkage -> I[10], I[9:6]
//   count           - number of single-bit shifts
//   stop_on_ct,cond - early stop enable and condition select -> I[5:0]
//   ct              - CT from the Am2904
//   abort           - cancel the running sequence (no done)
//   sh_I, sh_nSE    - Am2904 instruction and active-low shift enable
//   sh_nCEm,sh_nCEu - status register enables, held inactive
//   busy, done      - in SHIFT / one-cycle completion pulse
//   steps           - shifts performed by the last sequence
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic             dir,
  input  logic [3:0]       link,
  input  logic [CNT_W-1:0] count,
  input  logic             stop_on_ct,
  input  logic [5:0]       cond,
  input  logic             ct,
  input  logic             abort,
  output logic [12:0]      sh_I,
  output logic             sh_nSE,
  output logic             sh_nCEm,
  output logic             sh_nCEu,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps
);

  state_e     r_state, w_next;
  logic       r_dir;
  logic [3:0] r_link;
  logic       w_load, w_step, w_tc, w_stop;
  logic [5:0] w_cond;

`ifdef SHIFT_NORM_EN
  logic       r_stop_on_ct;
  logic [5:0] r_cond;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_stop_on_ct <= 1'b0;
      r_cond       <= '0;
    end else if (w_load) begin
      r_stop_on_ct <= stop_on_ct;
      r_cond       <= cond;
    end
  end

  // ct comes straight from the Am2904 and gates sh_nSE in the same cycle
  assign w_stop = r_stop_on_ct & ct;
  assign w_cond = r_cond;
`else
  logic w_unused_norm;
  assign w_unused_norm = ^{stop_on_ct, cond, ct};
  assign w_stop = 1'b0;
  assign w_cond = '0;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
      r_dir   <= 1'b0;
      r_link  <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_dir  <= dir;
        r_link <= link;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    sh_nSE = 1'b1;
    sh_I   = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = (count == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sh_I = mk_shift_i({r_dir, r_link}, w_cond);
        // abort outranks the stop test, which outranks the shift
        if (abort) begin
          w_next = ST_IDLE;
        end else if (w_stop) begin
          w_next = ST_DONE;
        end else begin
          sh_nSE = 1'b0;
          w_step = 1'b1;
          if (w_tc) w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  shift_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .nreset     (nreset),
    .i_load     (w_load),
    .i_load_val (count),
    .i_step     (w_step),
    .o_steps    (steps),
    .o_tc       (w_tc)
  );

  assign busy    = (r_state == ST_SHIFT);
  assign done    = (r_state == ST_DONE);
  assign sh_nCEm = 1'b1;
  assign sh_nCEu = 1'b1;

endmodule
